entrada_botao_ctrl: RTL and testbench

ENTRADA_BOTAO_CTRL -- requirements
Module: entrada_botao_ctrl

---
 rtl/entrada_botao_ctrl_pkg.sv | 14 +
 rtl/entrada_botao_ctrl_debounce_sinc.sv | 47 ++++
 rtl/entrada_botao_ctrl.sv | 138 +++++++++++++
 tb/tb_entrada_botao_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/entrada_botao_ctrl_pkg.sv
// Shared constants for the IN-port controller: FSM state encoding and data widths.
package entrada_botao_ctrl_pkg;

  localparam int DATA_W = 4;
  localparam int DADO_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    VALID   = 2'd2,
    RELEASE = 2'd3
  } estado_t;

endpackage

// File: rtl/entrada_botao_ctrl_debounce_sinc.sv
// Two-flop synchronizer followed by a debounce counter for one raw button input.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_sinc #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic sync_level,
  output logic deb_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             deb_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      deb_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any sample agreeing with the current level restarts the stability run.
      if (sync2_reg != deb_reg) begin
        if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign sync_level = sync2_reg;
  assign deb_level  = deb_reg;

endmodule

// File: rtl/entrada_botao_ctrl.sv
// IN-port controller: debounced push-button captures the synchronized switches for the CPU.
// Optional overrunIN output enabled by defining ENTRADA_OVERRUN_EN.
module entrada_botao_ctrl
  import entrada_botao_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        botaoPlaca,
  input  logic [3:0]  entradaDeDadosIO,
  input  logic        pedidoIN,
  input  logic        ackIN,
  output logic [31:0] dadoIN,
  output logic        validoIN,
  output logic        botaoIN,
  output logic [1:0]  estadoIN
`ifdef ENTRADA_OVERRUN_EN
  ,
  output logic        overrunIN
`endif
);

  logic              sync_level;
  logic              deb_level;
  logic [DATA_W-1:0] sw_sync;

  debounce_sinc #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce_sinc (
    .clock     (clock),
    .reset     (reset),
    .raw       (botaoPlaca),
    .sync_level(sync_level),
    .deb_level (deb_level)
  );

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sw_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= entradaDeDadosIO[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sw_sync[gi] = s2_reg;
    end
  endgenerate

  // hold_reg swallows the first debounced rise after reset until the button is seen
  // low, so a button held through reset cannot produce a press.
  logic       deb_prev_reg;
  logic       hold_reg;
  logic [1:0] fill_reg;
  logic       press_reg;
  logic       botao_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_prev_reg <= 1'b0;
      hold_reg     <= 1'b1;
      fill_reg     <= 2'b00;
      press_reg    <= 1'b0;
      botao_reg    <= 1'b0;
    end else begin
      fill_reg     <= {fill_reg[0], 1'b1};
      deb_prev_reg <= deb_level;
      press_reg    <= deb_level & ~deb_prev_reg & ~hold_reg;
      botao_reg    <= press_reg;
      if (fill_reg[1] && !sync_level && !deb_level) begin
        hold_reg <= 1'b0;
      end
    end
  end

  estado_t           estado_reg;
  logic              valido_reg;
  logic [DATA_W-1:0] dado_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg <= IDLE;
      valido_reg <= 1'b0;
      dado_reg   <= '0;
    end else begin
      case (estado_reg)
        IDLE: begin
          if (pedidoIN) estado_reg <= ARMED;
        end
        ARMED: begin
          if (press_reg) begin
            estado_reg <= VALID;
            dado_reg   <= sw_sync;
            valido_reg <= 1'b1;
          end else if (!pedidoIN) begin
            estado_reg <= IDLE;
          end
        end
        VALID: begin
          if (ackIN) begin
            estado_reg <= RELEASE;
            valido_reg <= 1'b0;
          end
        end
        RELEASE: begin
          if (!deb_level) estado_reg <= IDLE;
        end
        default: estado_reg <= IDLE;
      endcase
    end
  end

`ifdef ENTRADA_OVERRUN_EN
  // Every press outside ARMED is a discarded press.
  logic overrun_reg;
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (press_reg) begin
      overrun_reg <= (estado_reg != ARMED);
    end
  end
  assign overrunIN = overrun_reg;
`endif

  assign dadoIN   = {{(DADO_W - DATA_W){1'b0}}, dado_reg};
  assign validoIN = valido_reg;
  assign botaoIN  = botao_reg;
  assign estadoIN = estado_reg;

endmodule

// File: tb/tb_entrada_botao_ctrl.sv
// Bench for entrada_botao_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model built from the button/handshake rules.
module tb_entrada_botao_ctrl;

  localparam int DEB = 4;
  localparam int S_IDLE = 0, S_ARMED = 1, S_VALID = 2, S_RELEASE = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        botaoPlaca;
  logic [3:0]  entradaDeDadosIO;
  logic        pedidoIN;
  logic        ackIN;
  logic [31:0] dadoIN;
  logic        validoIN;
  logic        botaoIN;
  logic [1:0]  estadoIN;
`ifdef ENTRADA_OVERRUN_EN
  logic        overrunIN;
`endif

  entrada_botao_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .botaoPlaca      (botaoPlaca),
    .entradaDeDadosIO(entradaDeDadosIO),
    .pedidoIN        (pedidoIN),
    .ackIN           (ackIN),
    .dadoIN          (dadoIN),
    .validoIN        (validoIN),
    .botaoIN         (botaoIN),
    .estadoIN        (estadoIN)
`ifdef ENTRADA_OVERRUN_EN
    ,
    .overrunIN       (overrunIN)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state: values the design should show after the most recent clock edge.
  bit       m_s1, m_s2, m_deb, m_deb_prev, m_hold, m_press, m_botao;
  int       m_fill;
  bit [3:0] m_sw1, m_sw2, m_dado;
  int       m_state;
  bit       m_valid, m_over;
  bit       win[$];

  task automatic model_edge();
    bit all_diff;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0; m_hold = 1; m_press = 0; m_botao = 0;
      m_fill = 0; m_sw1 = 0; m_sw2 = 0; m_dado = 0; m_state = S_IDLE; m_valid = 0; m_over = 0;
      win.delete();
    end else begin
      // Handshake rules, driven by the press event and debounced level of the last cycle.
      case (m_state)
        S_IDLE: begin
          if (m_press) m_over = 1;
          if (pedidoIN) m_state = S_ARMED;
        end
        S_ARMED: begin
          if (m_press) begin
            m_state = S_VALID; m_dado = m_sw2; m_valid = 1; m_over = 0;
          end else if (!pedidoIN) begin
            m_state = S_IDLE;
          end
        end
        S_VALID: begin
          if (m_press) m_over = 1;
          if (ackIN) begin m_state = S_RELEASE; m_valid = 0; end
        end
        default: begin
          if (m_press) m_over = 1;
          if (!m_deb) m_state = S_IDLE;
        end
      endcase
      m_botao = m_press;
      m_press = m_deb && !m_deb_prev && !m_hold;
      if (m_fill >= 2 && !m_s2 && !m_deb) m_hold = 0;
      if (m_fill < 2) m_fill++;
      m_deb_prev = m_deb;
      // Level flips once the last DEB synchronized samples all disagree with it.
      win.push_back(m_s2);
      if (win.size() > DEB) void'(win.pop_front());
      all_diff = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_deb) all_diff = 0;
      if (all_diff) m_deb = !m_deb;
      m_s2 = m_s1; m_s1 = botaoPlaca;
      m_sw2 = m_sw1; m_sw1 = entradaDeDadosIO;
    end
  endtask

  int cyc = 0;
  int pulses = 0;
  int rise_cyc = -1;
  bit prev_valid = 0;

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
    check_eq("validoIN", validoIN, m_valid);
    check_eq("dadoIN", dadoIN, {28'b0, m_dado});
    check_eq("botaoIN", botaoIN, m_botao);
    check_eq("estadoIN", estadoIN, m_state);
`ifdef ENTRADA_OVERRUN_EN
    check_eq("overrunIN", overrunIN, m_over);
`endif
    if (botaoIN) pulses++;
    if (validoIN && !prev_valid) begin
      if (rise_cyc < 0) rise_cyc = cyc;
      $display("cycle %0d: value 0x%08h delivered", cyc, dadoIN);
    end
    prev_valid = validoIN;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int t0;
  int btn_left;
  bit saw_idle;

  initial begin
    reset = 1; botaoPlaca = 0; entradaDeDadosIO = 0; pedidoIN = 0; ackIN = 0;
    run(3);
    reset = 0;
    run(5);
    check_eq("rst_validoIN", validoIN, 0);
    check_eq("rst_dadoIN", dadoIN, 0);
    check_eq("rst_estadoIN", estadoIN, S_IDLE);

    // Clean press, switches = A.
    pedidoIN = 1; entradaDeDadosIO = 4'hA;
    run(4);
    check_eq("armed", estadoIN, S_ARMED);
    pulses = 0; rise_cyc = -1; t0 = cyc;
    botaoPlaca = 1; run(10);
    botaoPlaca = 0; run(10);
    check_eq("clean_latency", rise_cyc - t0, 8);
    check_eq("clean_dado", dadoIN, 32'h0000000A);
    check_eq("clean_pulses", pulses, 1);
    $display("scenario clean press done at cycle %0d", cyc);
    ackIN = 1; step(); ackIN = 0;
    run(4);

    // Bouncing press: 1,0,1,0 for 2 cycles each, then stable.
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      botaoPlaca = (k % 2 == 0); run(2);
    end
    botaoPlaca = 1; rise_cyc = -1; t0 = cyc;
    run(12);
    check_eq("bounce_pulses", pulses, 1);
    check_eq("bounce_latency", rise_cyc - t0, 8);
    $display("scenario bounce done at cycle %0d", cyc);

    // Ack while the button is still held.
    ackIN = 1; step(); ackIN = 0;
    check_eq("ack_valido_fall", validoIN, 0);
    check_eq("ack_release", estadoIN, S_RELEASE);
    run(5);
    check_eq("held_release", estadoIN, S_RELEASE);
    botaoPlaca = 0; saw_idle = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (estadoIN == 2'(S_IDLE)) saw_idle = 1;
    end
    check_eq("release_to_idle", saw_idle, 1);
    $display("scenario ack-while-held done at cycle %0d", cyc);

    // Second press while a value is pending.
    entradaDeDadosIO = 4'h5; run(3);
    botaoPlaca = 1; run(10); botaoPlaca = 0; run(8);
    check_eq("first_dado5", dadoIN, 32'h5);
    entradaDeDadosIO = 4'h3; run(3);
    pulses = 0;
    botaoPlaca = 1; run(10); botaoPlaca = 0; run(8);
    check_eq("overrun_dado", dadoIN, 32'h5);
    check_eq("overrun_valido", validoIN, 1);
    check_eq("overrun_pulse", pulses, 1);
`ifdef ENTRADA_OVERRUN_EN
    check_eq("overrun_flag", overrunIN, 1);
`endif
    $display("scenario overrun done at cycle %0d", cyc);
    ackIN = 1; step(); ackIN = 0;
    run(4);

    // Reset while VALID with the button held.
    entradaDeDadosIO = 4'h5; run(3);
    botaoPlaca = 1; run(10);
    check_eq("pre_reset_valido", validoIN, 1);
    reset = 1; step(); reset = 0;
    check_eq("reset_valido", validoIN, 0);
    check_eq("reset_dado", dadoIN, 0);
    pulses = 0;
    run(15);
    check_eq("held_no_pulse", pulses, 0);
    check_eq("held_no_valido", validoIN, 0);
    botaoPlaca = 0; run(10);
    botaoPlaca = 1; run(10);
    check_eq("repress_valido", validoIN, 1);
    check_eq("repress_dado", dadoIN, 32'h5);
    $display("scenario reset-in-valid done at cycle %0d", cyc);

    // Press with no pending IN request.
    botaoPlaca = 0; pedidoIN = 0;
    ackIN = 1; step(); ackIN = 0;
    run(10);
    check_eq("noreq_idle", estadoIN, S_IDLE);
    pulses = 0;
    botaoPlaca = 1; run(10); botaoPlaca = 0; run(8);
    check_eq("noreq_pulse", pulses, 1);
    check_eq("noreq_valido", validoIN, 0);
    check_eq("noreq_estado", estadoIN, S_IDLE);
    $display("scenario press-without-request done at cycle %0d", cyc);

    // Random stimulus against the model.
    btn_left = 1; pedidoIN = 1;
    for (int i = 0; i < 3000; i++) begin
      btn_left--;
      if (btn_left <= 0) begin
        botaoPlaca = ~botaoPlaca;
        btn_left = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 15) == 0) entradaDeDadosIO = 4'($urandom);
      if ($urandom_range(0, 19) == 0) pedidoIN = ~pedidoIN;
      ackIN = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 0; ackIN = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
